// File: rtl/fir_window_gen.sv
// fir_window_gen
// Builds the 3x3 pixel neighbourhood for every pixel of a raster-scan frame.
// Two line buffers hold the previous two image lines; a 3x3 tap shift
// register holds the current window columns. One window is emitted per
// centre pixel, in raster order, with valid/ready flow control.
//
// Optional build macro: FIR_WINDOW_REPLICATE_EN
//   defined   : out-of-image taps replicate the nearest in-image pixel
//   undefined : out-of-image taps are zero
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   frame_start  one-cycle pulse, arms a new frame (honoured only when idle)
//   in_data      input pixel {R,G,B}, raster order
//   in_valid     in_data valid
//   in_ready     pixel accepted this cycle when in_valid & in_ready
//   win_data     taps t0..t8, t0 in LSBs, row-major around the centre
//   win_valid    win_data holds a window
//   win_ready    downstream takes the window
//   win_last     window centred at the last pixel of the frame
//   busy         generator is inside a frame
module fir_window_gen #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic [PIX_W-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [9*PIX_W-1:0] win_data,
    output logic               win_valid,
    input  logic               win_ready,
    output logic               win_last,
    output logic               busy
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_ZERO = {CW{1'b0}};
    localparam logic [RW-1:0] ROW_ZERO = {RW{1'b0}};
    localparam logic [CW-1:0] COL_ONE = CW'(1);
    localparam logic [RW-1:0] ROW_ONE = RW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t              state_r;
    logic [CW-1:0]       in_col_r;
    logic [RW-1:0]       in_row_r;
    logic [CW-1:0]       ctr_col_r;
    logic [RW-1:0]       ctr_row_r;
    logic [9*PIX_W-1:0]  win_data_r;
    logic                win_valid_r;
    logic                win_last_r;

    logic [PIX_W-1:0]    lb0_r [IMG_W];
    logic [PIX_W-1:0]    lb1_r [IMG_W];
    logic [PIX_W-1:0]    raw_r   [3][3];
    logic [PIX_W-1:0]    raw_n_s [3][3];
    logic [9*PIX_W-1:0]  win_next_s;

    logic                slot_free_s;
    logic                in_ready_s;
    logic                accept_s;
    logic                flush_gen_s;
    logic                step_s;
    logic                gen_s;
    logic [PIX_W-1:0]    pix_s;

    assign in_ready  = in_ready_s;
    assign win_data  = win_data_r;
    assign win_valid = win_valid_r;
    assign win_last  = win_last_r;
    assign busy      = (state_r != ST_IDLE);

    // Handshake decode: accept, flush generation and window generation strobes.
    always_comb begin
        slot_free_s = !win_valid_r || win_ready;
        in_ready_s  = ((state_r == ST_FILL) || (state_r == ST_RUN)) && slot_free_s;
        accept_s    = in_ready_s && in_valid;
        // Once the last window sits in the output register, flush stops generating.
        flush_gen_s = (state_r == ST_FLUSH) && slot_free_s && !(win_valid_r && win_last_r);
        step_s      = accept_s || flush_gen_s;
        gen_s       = (accept_s && (state_r == ST_RUN)) || flush_gen_s;
        if (state_r == ST_FLUSH) begin
            pix_s = {PIX_W{1'b0}};
        end else begin
            pix_s = in_data;
        end
    end

    // Next tap array: shift left one column, new right column from the line
    // buffers (two lines up, one line up) and the incoming pixel.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            raw_n_s[i][0] = raw_r[i][1];
            raw_n_s[i][1] = raw_r[i][2];
        end
        raw_n_s[0][2] = lb1_r[in_col_r];
        raw_n_s[1][2] = lb0_r[in_col_r];
        raw_n_s[2][2] = pix_s;
    end

    // Border handling of the next window, driven by the centre counters so a
    // tap beyond the right edge never picks up the next line's first pixel.
    always_comb begin
        int  si;
        int  sj;
        logic row_out;
        logic col_out;
        win_next_s = {(9*PIX_W){1'b0}};
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                row_out = ((i == 0) && (ctr_row_r == ROW_ZERO)) ||
                          ((i == 2) && (ctr_row_r == ROW_MAX));
                col_out = ((j == 0) && (ctr_col_r == COL_ZERO)) ||
                          ((j == 2) && (ctr_col_r == COL_MAX));
`ifdef FIR_WINDOW_REPLICATE_EN
                // Clamp to the centre row/column: that is the nearest in-image pixel.
                si = row_out ? 1 : i;
                sj = col_out ? 1 : j;
                win_next_s[(i*3+j)*PIX_W +: PIX_W] = raw_n_s[si][sj];
`else
                si = i;
                sj = j;
                if (row_out || col_out) begin
                    win_next_s[(i*3+j)*PIX_W +: PIX_W] = {PIX_W{1'b0}};
                end else begin
                    win_next_s[(i*3+j)*PIX_W +: PIX_W] = raw_n_s[si][sj];
                end
`endif
            end
        end
    end

    // Line buffer and tap storage: one read and one write per buffer per step.
    always_ff @(posedge clk) begin
        if (step_s) begin
            lb1_r[in_col_r] <= lb0_r[in_col_r];
            lb0_r[in_col_r] <= pix_s;
            raw_r           <= raw_n_s;
        end
    end

    // Frame FSM, input/centre counters and registered window output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_col_r    <= COL_ZERO;
            in_row_r    <= ROW_ZERO;
            ctr_col_r   <= COL_ZERO;
            ctr_row_r   <= ROW_ZERO;
            win_data_r  <= {(9*PIX_W){1'b0}};
            win_valid_r <= 1'b0;
            win_last_r  <= 1'b0;
        end else begin
            // Input position advances on every step, including flush steps,
            // so the line-buffer address keeps tracking the virtual pixel.
            if (step_s) begin
                if (in_col_r == COL_MAX) begin
                    in_col_r <= COL_ZERO;
                    in_row_r <= (in_row_r == ROW_MAX) ? ROW_ZERO : (in_row_r + ROW_ONE);
                end else begin
                    in_col_r <= in_col_r + COL_ONE;
                end
            end

            // Centre position of the next window to be produced.
            if (gen_s) begin
                if (ctr_col_r == COL_MAX) begin
                    ctr_col_r <= COL_ZERO;
                    ctr_row_r <= (ctr_row_r == ROW_MAX) ? ROW_ZERO : (ctr_row_r + ROW_ONE);
                end else begin
                    ctr_col_r <= ctr_col_r + COL_ONE;
                end
            end

            if (gen_s) begin
                win_data_r  <= win_next_s;
                win_valid_r <= 1'b1;
                win_last_r  <= (ctr_row_r == ROW_MAX) && (ctr_col_r == COL_MAX);
            end else if (win_ready) begin
                win_valid_r <= 1'b0;
                win_last_r  <= 1'b0;
            end else begin
                win_valid_r <= win_valid_r;
                win_last_r  <= win_last_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_r   <= ST_FILL;
                        in_col_r  <= COL_ZERO;
                        in_row_r  <= ROW_ZERO;
                        ctr_col_r <= COL_ZERO;
                        ctr_row_r <= ROW_ZERO;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    // Pixel n = IMG_W is row 1, column 0.
                    if (accept_s && (in_row_r == ROW_ONE) && (in_col_r == COL_ZERO)) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_FILL;
                    end
                end
                ST_RUN: begin
                    if (accept_s && (in_row_r == ROW_MAX) && (in_col_r == COL_MAX)) begin
                        state_r <= ST_FLUSH;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (win_valid_r && win_last_r && win_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_FLUSH;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_window_gen.sv
module tb_fir_window_gen;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int PW = 24;
    localparam int N  = W * H;
    localparam int WD = 9 * PW;

`ifdef FIR_WINDOW_REPLICATE_EN
    localparam bit REPL = 1'b1;
`else
    localparam bit REPL = 1'b0;
`endif

    // Expected taps for named windows of the ramp frame (zero / replicate builds).
    localparam logic [23:0] E0Z [9] = '{24'h0, 24'h0, 24'h0, 24'h0, 24'h010101, 24'h020202, 24'h0, 24'h050505, 24'h060606};
    localparam logic [23:0] E0R [9] = '{24'h010101, 24'h010101, 24'h020202, 24'h010101, 24'h010101, 24'h020202, 24'h050505, 24'h050505, 24'h060606};
    localparam logic [23:0] E7Z [9] = '{24'h030303, 24'h040404, 24'h0, 24'h070707, 24'h080808, 24'h0, 24'h0B0B0B, 24'h0C0C0C, 24'h0};
    localparam logic [23:0] E7R [9] = '{24'h030303, 24'h040404, 24'h040404, 24'h070707, 24'h080808, 24'h080808, 24'h0B0B0B, 24'h0C0C0C, 24'h0C0C0C};
    localparam logic [23:0] ELZ [9] = '{24'h070707, 24'h080808, 24'h0, 24'h0B0B0B, 24'h0C0C0C, 24'h0, 24'h0, 24'h0, 24'h0};
    localparam logic [23:0] ELR [9] = '{24'h070707, 24'h080808, 24'h080808, 24'h0B0B0B, 24'h0C0C0C, 24'h0C0C0C, 24'h0B0B0B, 24'h0C0C0C, 24'h0C0C0C};

    logic          clk;
    logic          rst_n;
    logic          frame_start;
    logic [PW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [WD-1:0] win_data;
    logic          win_valid;
    logic          win_ready;
    logic          win_last;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] pix [N];
    logic [WD-1:0] got_q [$];
    logic          got_last_q [$];
    int            stall_bad = 0;
    logic          prev_stall = 1'b0;
    logic [WD-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    int first_v_iter;
    int acc_w1_iter;
    int flush_rdy_bad;
    int pre_flush;
    bit timeout;
    logic busy_after;

    fir_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .win_data(win_data), .win_valid(win_valid), .win_ready(win_ready),
        .win_last(win_last), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Transfer recorder and output-stability watcher during stalls.
    always @(posedge clk) begin
        if (rst_n && win_valid && win_ready) begin
            got_q.push_back(win_data);
            got_last_q.push_back(win_last);
        end
        if (rst_n && prev_stall &&
            ((win_valid !== 1'b1) || (win_data !== prev_data) || (win_last !== prev_last))) begin
            stall_bad <= stall_bad + 1;
        end
        prev_stall <= rst_n && win_valid && !win_ready;
        prev_data  <= win_data;
        prev_last  <= win_last;
    end

    task automatic chk(input string tag, input logic [WD-1:0] obs, input logic [WD-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] tap(input logic [WD-1:0] w, input int t);
        return w[t*PW +: PW];
    endfunction

    // Reference window: tap (dr,dc) around centre k, straight from the frame array.
    function automatic logic [WD-1:0] exp_win(input int k);
        logic [WD-1:0] w;
        int r, c;
        w = '0;
        for (int t = 0; t < 9; t++) begin
            r = k / W + t / 3 - 1;
            c = k % W + t % 3 - 1;
            if (r >= 0 && r < H && c >= 0 && c < W) begin
                w[t*PW +: PW] = pix[r*W + c];
            end else if (REPL) begin
                r = (r < 0) ? 0 : ((r > H - 1) ? H - 1 : r);
                c = (c < 0) ? 0 : ((c > W - 1) ? W - 1 : c);
                w[t*PW +: PW] = pix[r*W + c];
            end
        end
        return w;
    endfunction

    task automatic ramp_frame();
        logic [PW-1:0] m;
        m = 24'h010101;
        for (int n = 0; n < N; n++) pix[n] = m * PW'(n + 1);
    endtask

    task automatic run_frame(input bit stress);
        int idx;
        int it;
        bit pre_done;
        idx = 0; it = 0; pre_done = 0;
        got_q.delete(); got_last_q.delete();
        first_v_iter = -1; acc_w1_iter = -1; flush_rdy_bad = 0; pre_flush = -1; timeout = 0;
        @(negedge clk);
        frame_start = 1'b1;
        in_valid = 1'b0;
        win_ready = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        while (got_q.size() < N) begin
            if (it > 2000) begin
                timeout = 1;
                break;
            end
            win_ready = stress ? it[0] : 1'b1;
            // After the last pixel, in_valid stays up with junk so a wrong accept shows.
            in_valid  = (idx < N) ? (stress ? ($urandom_range(0, 1) == 1) : 1'b1) : 1'b1;
            in_data   = (idx < N) ? pix[idx] : PW'($urandom);
            #1;
            if (first_v_iter < 0 && win_valid) first_v_iter = it;
            if (idx >= N && in_ready) flush_rdy_bad++;
            if (idx == N && !pre_done) begin
                pre_flush = got_q.size() + int'(win_valid);
                pre_done = 1;
            end
            if (in_valid && in_ready && idx < N) begin
                if (idx == W + 1) acc_w1_iter = it;
                idx++;
            end
            @(negedge clk);
            it++;
        end
        in_valid = 1'b0;
        #1;
        busy_after = busy;
    endtask

    task automatic check_frame(input string nm);
        chk({nm, "_timeout"}, WD'(timeout), WD'(0));
        while (got_q.size() < N) begin
            got_q.push_back('x);
            got_last_q.push_back(1'bx);
        end
        chk({nm, "_count"}, WD'(got_q.size()), WD'(N));
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s_win%0d", nm, k), got_q[k], exp_win(k));
            chk($sformatf("%s_last%0d", nm, k), WD'(got_last_q[k]), WD'(k == N - 1));
        end
        chk({nm, "_run_windows"}, WD'(pre_flush), WD'(N - W - 1));
        chk({nm, "_flush_in_ready"}, WD'(flush_rdy_bad), WD'(0));
        chk({nm, "_busy_after"}, WD'(busy_after), WD'(0));
        chk({nm, "_stall_hold"}, WD'(stall_bad), WD'(0));
    endtask

    initial begin
        int acc;
        int guard;
        rst_n = 1'b0; frame_start = 1'b0; in_data = '0; in_valid = 1'b0; win_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", WD'(in_ready), WD'(0));
        chk("rst_win_valid", WD'(win_valid), WD'(0));
        chk("rst_win_last", WD'(win_last), WD'(0));
        chk("rst_busy", WD'(busy), WD'(0));
        chk("rst_win_data", win_data, WD'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Ramp frame, no back-pressure.
        ramp_frame();
        run_frame(1'b0);
        chk("f1_first_valid", WD'(first_v_iter), WD'(acc_w1_iter + 1));
        check_frame("f1");
        for (int t = 0; t < 9; t++) begin
            chk($sformatf("f1_c00_t%0d", t), WD'(tap(got_q[0], t)), WD'(REPL ? E0R[t] : E0Z[t]));
            chk($sformatf("f1_c13_t%0d", t), WD'(tap(got_q[7], t)), WD'(REPL ? E7R[t] : E7Z[t]));
            chk($sformatf("f1_c23_t%0d", t), WD'(tap(got_q[N-1], t)), WD'(REPL ? ELR[t] : ELZ[t]));
        end

        // Random pixels, random in_valid, win_ready toggling every cycle.
        for (int n = 0; n < N; n++) pix[n] = PW'($urandom);
        run_frame(1'b1);
        check_frame("stall");

        // Abandon a frame after 7 accepted pixels with a reset.
        ramp_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        acc = 0; guard = 0;
        while (acc < 7 && guard < 200) begin
            in_valid = 1'b1; win_ready = 1'b1; in_data = pix[acc];
            #1;
            if (in_ready) acc++;
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        chk("mid_accepted", WD'(acc), WD'(7));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", WD'(in_ready), WD'(0));
        chk("mid_rst_win_valid", WD'(win_valid), WD'(0));
        chk("mid_rst_win_last", WD'(win_last), WD'(0));
        chk("mid_rst_busy", WD'(busy), WD'(0));
        chk("mid_rst_win_data", win_data, WD'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_frame(1'b0);
        check_frame("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
